// File: rtl/boid_fb_pkg.sv
// Shared types and default geometry for the boid framebuffer renderer.
package boid_fb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        PLOT,
        DONE
    } state_t;

    localparam int DEF_NUM_BOIDS  = 32;
    localparam int DEF_FB_WIDTH   = 320;
    localparam int DEF_FB_HEIGHT  = 240;
    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_BOID_SIZE  = 2;
    localparam int X_WIDTH        = 9;
    localparam int Y_WIDTH        = 8;

    localparam int FB_PIXELS = DEF_FB_WIDTH * DEF_FB_HEIGHT;

endpackage

// File: rtl/boid_fb_ram.sv
// Simple dual-port 1-bit framebuffer bank: write port plus registered, read-first read port.
module boid_fb_ram
    import boid_fb_pkg::*;
#(
    parameter int DEPTH = FB_PIXELS,
    parameter int AW    = DEF_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_data
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && wr_addr < LIMIT) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // Contents are never reset; only the output register is.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 1'b0;
        end else if (rd_addr < LIMIT) begin
            rd_data <= mem[rd_addr[IW-1:0]];
        end else begin
            rd_data <= 1'b0;
        end
    end

endmodule

// File: rtl/boid_frame_renderer.sv
// Clears and redraws the 1-bit boid framebuffer once per frame and serves it to the VGA read port.
// Optional double buffering via BOID_DOUBLE_BUFFER_EN.
module boid_frame_renderer
    import boid_fb_pkg::*;
#(
    parameter int NUM_BOIDS  = DEF_NUM_BOIDS,
    parameter int FB_WIDTH   = DEF_FB_WIDTH,
    parameter int FB_HEIGHT  = DEF_FB_HEIGHT,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BOID_SIZE  = DEF_BOID_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_start,
    output logic                         boid_req,
    output logic [$clog2(NUM_BOIDS)-1:0] boid_idx,
    input  logic                         boid_valid,
    input  logic [X_WIDTH-1:0]           boid_x,
    input  logic [Y_WIDTH-1:0]           boid_y,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic                         rd_data,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         overrun
);

    localparam int IDX_W  = $clog2(NUM_BOIDS);
    localparam int PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] W_A      = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] H_A      = ADDR_WIDTH'(FB_HEIGHT);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_BOIDS - 1);
    localparam logic [2:0]            LAST_OFF = 3'(BOID_SIZE - 1);

    state_t                state;
    logic                  fs_q, fs_q2, fs_edge;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [X_WIDTH-1:0]    bx;
    logic [Y_WIDTH-1:0]    by;
    logic [2:0]            off_i, off_j;
    logic [ADDR_WIDTH-1:0] col, row, pix_addr, wr_addr;
    logic                  pix_in, we, wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            fs_q    <= 1'b0;
            fs_q2   <= 1'b0;
            fs_edge <= 1'b0;
        end else begin
            fs_q    <= frame_start;
            fs_q2   <= fs_q;
            fs_edge <= fs_q & ~fs_q2;
        end
    end

    // Full-width arithmetic so off-screen pixels are detected rather than wrapped.
    always_comb begin
        col      = ADDR_WIDTH'(bx) + ADDR_WIDTH'(off_i);
        row      = ADDR_WIDTH'(by) + ADDR_WIDTH'(off_j);
        pix_in   = (col < W_A) && (row < H_A);
        pix_addr = col + W_A * row;
        we       = 1'b0;
        wr_data  = 1'b0;
        wr_addr  = clr_addr;
        if (state == CLEAR) begin
            we = 1'b1;
        end else if (state == PLOT && pix_in) begin
            we      = 1'b1;
            wr_data = 1'b1;
            wr_addr = pix_addr;
        end
    end

`ifdef BOID_DOUBLE_BUFFER_EN
    logic front, front_q, rd0, rd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            boid_req   <= 1'b0;
            boid_idx   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            clr_addr   <= '0;
            bx         <= '0;
            by         <= '0;
            off_i      <= '0;
            off_j      <= '0;
`ifdef BOID_DOUBLE_BUFFER_EN
            front      <= 1'b0;
            front_q    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
`ifdef BOID_DOUBLE_BUFFER_EN
            front_q    <= front;
`endif
            if (fs_edge && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (fs_edge) begin
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        clr_addr <= '0;
`ifdef BOID_DOUBLE_BUFFER_EN
                        front    <= ~front;
`endif
                    end
                end
                CLEAR: begin
                    if (clr_addr == LAST_PIX) begin
                        state    <= FETCH;
                        boid_idx <= '0;
                        boid_req <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                FETCH: begin
                    if (boid_valid) begin
                        bx       <= boid_x;
                        by       <= boid_y;
                        boid_req <= 1'b0;
                        off_i    <= '0;
                        off_j    <= '0;
                        state    <= PLOT;
                    end
                end
                PLOT: begin
                    if (off_i == LAST_OFF) begin
                        off_i <= '0;
                        if (off_j == LAST_OFF) begin
                            off_j <= '0;
                            if (boid_idx == LAST_IDX) begin
                                state <= DONE;
                            end else begin
                                boid_idx <= boid_idx + 1'b1;
                                boid_req <= 1'b1;
                                state    <= FETCH;
                            end
                        end else begin
                            off_j <= off_j + 1'b1;
                        end
                    end else begin
                        off_i <= off_i + 1'b1;
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BOID_DOUBLE_BUFFER_EN
    // Render into the bank the pointer does not select; front_q tracks the bank behind rd_data.
    boid_fb_ram #(.DEPTH(PIXELS), .AW(ADDR_WIDTH)) u_bank0 (
        .clk(clk), .reset(reset), .we(we & front), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd0)
    );
    boid_fb_ram #(.DEPTH(PIXELS), .AW(ADDR_WIDTH)) u_bank1 (
        .clk(clk), .reset(reset), .we(we & ~front), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd1)
    );
    assign rd_data = front_q ? rd1 : rd0;
`else
    boid_fb_ram #(.DEPTH(PIXELS), .AW(ADDR_WIDTH)) u_bank0 (
        .clk(clk), .reset(reset), .we(we), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );
`endif

endmodule

// File: tb/tb_boid_frame_renderer.sv
// Scoreboard bench for boid_frame_renderer; a short framebuffer keeps the run brief.
module tb_boid_frame_renderer;

    localparam int W   = 320;
    localparam int H   = 24;
    localparam int NB  = 32;
    localparam int S   = 2;
    localparam int AW  = 20;
    localparam int PIX = W * H;
    localparam int BASE_LEN = PIX + NB * (1 + S * S) + 1;

    logic          clk = 1'b0;
    logic          reset, frame_start, boid_req, boid_valid;
    logic [4:0]    boid_idx;
    logic [8:0]    boid_x;
    logic [7:0]    boid_y;
    logic [AW-1:0] rd_addr;
    logic          rd_data, busy, frame_done, overrun;

    int checks = 0, failures = 0, cyc = 0, done_cnt = 0;
    int pos_set = 0, delay_boid = -1, delay_len = 0, wait_cnt = 0;
    bit in_wait = 1'b0;

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       tag;
    } rd_item_t;
    rd_item_t rdq[$];

    boid_frame_renderer #(
        .NUM_BOIDS(NB), .FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_WIDTH(AW), .BOID_SIZE(S)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .boid_req(boid_req), .boid_idx(boid_idx), .boid_valid(boid_valid),
        .boid_x(boid_x), .boid_y(boid_y), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (frame_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int px(input int set, input int i);
        if (set == 0) return (i == 0) ? 10 : (i == 1) ? 319 : (i == 2) ? 0 : (i * 37) % W;
        return (i == 0) ? 100 : (i * 53 + 7) % W;
    endfunction

    function automatic int py(input int set, input int i);
        if (set == 0) return (i == 0) ? 20 : (i == 1) ? H - 1 : (i == 2) ? 0 : (i * 5) % H;
        return (i == 0) ? 5 : (i * 3 + 1) % H;
    endfunction

    function automatic bit model_pix(input int set, input int addr);
        int c, r;
        if (addr >= PIX) return 1'b0;
        c = addr % W;
        r = addr / W;
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < S; j++)
                for (int i = 0; i < S; i++)
                    if (px(set, b) + i == c && py(set, b) + j == r) return 1'b1;
        return 1'b0;
    endfunction

    // Boid state memory model; optionally stalls one request to exercise the handshake.
    always @(negedge clk) begin
        if (in_wait) begin
            check("req_hold", {31'b0, boid_req}, 1);
            check("idx_hold", {27'b0, boid_idx}, delay_boid);
            wait_cnt++;
            if (wait_cnt > delay_len) begin
                in_wait    = 1'b0;
                delay_boid = -1;
                boid_valid = 1'b1;
                boid_x     = 9'(px(pos_set, int'(boid_idx)));
                boid_y     = 8'(py(pos_set, int'(boid_idx)));
            end else begin
                boid_valid = 1'b0;
            end
        end else if (boid_req && int'(boid_idx) == delay_boid) begin
            in_wait    = 1'b1;
            wait_cnt   = 1;
            boid_valid = 1'b0;
        end else if (boid_req) begin
            boid_valid = 1'b1;
            boid_x     = 9'(px(pos_set, int'(boid_idx)));
            boid_y     = 8'(py(pos_set, int'(boid_idx)));
        end else begin
            boid_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rdq.size() > 0 && rdq[0].due <= cyc) begin
            rd_item_t it;
            it = rdq.pop_front();
            check(it.tag, {31'b0, rd_data}, it.exp);
        end
    end

    task automatic issue_read(input logic [AW-1:0] a, input bit e, input string tag);
        rd_item_t it;
        @(negedge clk);
        rd_addr = a;
        it.exp  = {31'b0, e};
        it.due  = cyc + 1;
        it.tag  = tag;
        rdq.push_back(it);
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && rdq.size() > 0; n++) @(negedge clk);
        check("rd_drain", rdq.size(), 0);
    endtask

    task automatic scan(input int set);
        for (int a = 0; a < PIX; a++) issue_read(AW'(a), model_pix(set, a), "pix");
        issue_read(AW'(PIX), 1'b0, "oob_end");
        issue_read({AW{1'b1}}, 1'b0, "oob_max");
        drain();
    endtask

    task automatic spot_checks();
        issue_read(20'd6410, 1'b1, "b0_6410");
        issue_read(20'd6411, 1'b1, "b0_6411");
        issue_read(20'd6730, 1'b1, "b0_6730");
        issue_read(20'd6731, 1'b1, "b0_6731");
        issue_read(20'd6409, 1'b0, "b0_6409");
        issue_read(20'd6412, 1'b0, "b0_6412");
        issue_read(AW'(PIX - 1), 1'b1, "corner");
        issue_read(AW'(PIX - W), 1'b0, "no_wrap_col0");
        issue_read(AW'(PIX - 2), 1'b0, "corner_left");
        drain();
    endtask

    task automatic run_frame(input int extra);
        int start, rise, done;
        rise = -1;
        done = -1;
        @(negedge clk);
        frame_start = 1'b1;
        start = cyc;
        for (int n = 1; n <= PIX + 1000; n++) begin
            @(negedge clk);
            if (n == 4) frame_start = 1'b0;
            if (busy && rise < 0) rise = cyc;
            if (frame_done) begin
                done = cyc;
                break;
            end
        end
        frame_start = 1'b0;
        check("busy_rise", rise - start, 3);
        check("frame_len", done - rise, BASE_LEN + extra);
        @(negedge clk);
        check("done_pulse", {31'b0, frame_done}, 0);
        check("idle_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        int start, done, d0;
        reset = 1'b1; frame_start = 1'b0; boid_valid = 1'b0;
        boid_x = '0; boid_y = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'b0, boid_req}, 0);
        check("rst_idx", {27'b0, boid_idx}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, frame_done}, 0);
        check("rst_overrun", {31'b0, overrun}, 0);
        check("rst_rd", {31'b0, rd_data}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        pos_set = 0;
        run_frame(0);
`ifndef BOID_DOUBLE_BUFFER_EN
        spot_checks();
        scan(0);
`endif
        pos_set = 1;
        delay_boid = 3;
        delay_len  = 7;
        run_frame(7);
`ifdef BOID_DOUBLE_BUFFER_EN
        spot_checks();
        scan(0);
`else
        scan(1);
`endif

        // Second frame_start during CLEAR: flagged, not restarted.
        pos_set = 0;
        d0 = done_cnt;
        done = -1;
        @(negedge clk);
        frame_start = 1'b1;
        start = cyc;
        repeat (4) @(negedge clk);
        frame_start = 1'b0;
        repeat (100) @(negedge clk);
        check("busy_in_clear", {31'b0, busy}, 1);
        check("no_overrun_yet", {31'b0, overrun}, 0);
        frame_start = 1'b1;
        repeat (4) @(negedge clk);
        frame_start = 1'b0;
        repeat (4) @(negedge clk);
        check("overrun_set", {31'b0, overrun}, 1);
        for (int n = 0; n < PIX + 1000; n++) begin
            @(negedge clk);
            if (frame_done) begin
                done = cyc;
                break;
            end
        end
        check("ovr_frame_len", done - start, 3 + BASE_LEN);
        repeat (300) @(negedge clk);
        check("single_render", done_cnt - d0, 1);
        check("overrun_sticky", {31'b0, overrun}, 1);
`ifdef BOID_DOUBLE_BUFFER_EN
        scan(1);
`endif
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {31'b0, overrun}, 0);
        check("busy_cleared", {31'b0, busy}, 0);

        // Reset part-way through a frame abandons it.
        d0 = done_cnt;
        frame_start = 1'b1;
        repeat (4) @(negedge clk);
        frame_start = 1'b0;
        repeat (30) @(negedge clk);
        check("busy_mid", {31'b0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_req", {31'b0, boid_req}, 0);
        repeat (40) @(negedge clk);
        check("abort_idle", {31'b0, busy}, 0);
        check("abort_no_done", done_cnt - d0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
